// File: rtl/urv_divide_if.sv
// Decode/execute handshake bundle for the iterative divider.
// Decode drives operands and the stall; the divider returns busy, done and rd.
// Decode must hold its instruction while x_busy_o is high.
interface urv_divide_if;
  logic        x_stall_i;
  logic        d_valid_i;
  logic [31:0] d_rs1_i;
  logic [31:0] d_rs2_i;
  logic [2:0]  d_fun_i;
  logic        x_busy_o;
  logic        x_done_o;
  logic [31:0] x_rd_o;

  modport master (
    output x_stall_i, d_valid_i, d_rs1_i, d_rs2_i, d_fun_i,
    input  x_busy_o, x_done_o, x_rd_o
  );

  modport slave (
    input  x_stall_i, d_valid_i, d_rs1_i, d_rs2_i, d_fun_i,
    output x_busy_o, x_done_o, x_rd_o
  );
endinterface

// File: rtl/urv_divide.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Latency: done 33 edges after accept (1 edge for rs2==0 in fast mode), +1 per stalled cycle.
// Backpressure: x_stall_i freezes everything; requests while busy are ignored.
module urv_divide #(
  parameter bit g_fast_div_by_zero = 1'b0
) (
  input logic       clk_i,
  input logic       rst_i,
  urv_divide_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] quo_q, rem_q, dvs_q, rs1_raw_q, rd_q;
  logic        signed_q, rem_sel_q, n1_q, n2_q, div0_q, ovf_q;

  logic        accept, rs2_zero, op_signed, rs1_neg, rs2_neg;
  logic [32:0] shifted, trial;
  logic        trial_ge;
  logic [31:0] quo_fix, rem_fix, result;

  assign rs2_zero  = (bus.d_rs2_i == 32'd0);
  assign op_signed = ~bus.d_fun_i[0];
  assign rs1_neg   = op_signed & bus.d_rs1_i[31];
  assign rs2_neg   = op_signed & bus.d_rs2_i[31];
  assign accept    = bus.d_valid_i & bus.d_fun_i[2] & ~bus.x_stall_i &
                     ((state_q == S_IDLE) | (state_q == S_DONE));

  // One restoring step: shift {rem,quo} left, subtract divisor; the borrow
  // bit of the 33-bit difference tells whether the trial fits.
  assign shifted  = {rem_q, quo_q[31]};
  assign trial    = shifted - {1'b0, dvs_q};
  assign trial_ge = ~trial[32];

  // Sign correction and special-case overrides applied in FIX.
  always_comb begin
    quo_fix = (signed_q & (n1_q ^ n2_q)) ? -quo_q : quo_q;
    rem_fix = (signed_q & n1_q) ? -rem_q : rem_q;
    result  = rem_sel_q ? rem_fix : quo_fix;
    if (div0_q)
      result = rem_sel_q ? rs1_raw_q : 32'hFFFF_FFFF;
    else if (ovf_q)
      result = rem_sel_q ? 32'h0000_0000 : 32'h8000_0000;
  end

  // Next-state logic; a stall holds the current state.
  always_comb begin
    state_d = state_q;
    if (!bus.x_stall_i) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept)
            state_d = (g_fast_div_by_zero && rs2_zero) ? S_FIX : S_CALC;
          else
            state_d = S_IDLE;
        end
        S_CALC:  if (cnt_q == 5'd31) state_d = S_FIX;
        S_FIX:   state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath: latch operands on accept, step in CALC, register rd in FIX.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= 5'd0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      dvs_q     <= 32'd0;
      rs1_raw_q <= 32'd0;
      rd_q      <= 32'd0;
      signed_q  <= 1'b0;
      rem_sel_q <= 1'b0;
      n1_q      <= 1'b0;
      n2_q      <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (!bus.x_stall_i) begin
      if (accept) begin
        cnt_q     <= 5'd0;
        quo_q     <= rs1_neg ? -bus.d_rs1_i : bus.d_rs1_i;
        dvs_q     <= rs2_neg ? -bus.d_rs2_i : bus.d_rs2_i;
        rem_q     <= 32'd0;
        rs1_raw_q <= bus.d_rs1_i;
        signed_q  <= op_signed;
        rem_sel_q <= bus.d_fun_i[1];
        n1_q      <= rs1_neg;
        n2_q      <= rs2_neg;
        div0_q    <= rs2_zero;
        ovf_q     <= op_signed & (bus.d_rs1_i == 32'h8000_0000) &
                     (bus.d_rs2_i == 32'hFFFF_FFFF);
      end else if (state_q == S_CALC) begin
        rem_q <= trial_ge ? trial[31:0] : shifted[31:0];
        quo_q <= {quo_q[30:0], trial_ge};
        cnt_q <= cnt_q + 5'd1;
      end else if (state_q == S_FIX) begin
        rd_q <= result;
      end
    end
  end

  assign bus.x_busy_o = (state_q == S_CALC) | (state_q == S_FIX);
  assign bus.x_done_o = (state_q == S_DONE);
  assign bus.x_rd_o   = rd_q;

endmodule

// File: tb/tb_urv_divide.sv
// Directed bench for urv_divide: a normal-latency and a fast-div-by-zero
// instance receive identical stimulus; results and latencies are checked
// against hand-computed values.
module tb_urv_divide;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        stall = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic [2:0]  fun = 3'd0;

  urv_divide_if bus_s ();
  urv_divide_if bus_f ();

  assign bus_s.x_stall_i = stall;
  assign bus_s.d_valid_i = valid;
  assign bus_s.d_rs1_i   = rs1;
  assign bus_s.d_rs2_i   = rs2;
  assign bus_s.d_fun_i   = fun;
  assign bus_f.x_stall_i = stall;
  assign bus_f.d_valid_i = valid;
  assign bus_f.d_rs1_i   = rs1;
  assign bus_f.d_rs2_i   = rs2;
  assign bus_f.d_fun_i   = fun;

  urv_divide #(.g_fast_div_by_zero(1'b0)) u_slow (.clk_i(clk), .rst_i(rst), .bus(bus_s));
  urv_divide #(.g_fast_div_by_zero(1'b1)) u_fast (.clk_i(clk), .rst_i(rst), .bus(bus_f));

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  typedef struct {
    logic [2:0]  fun;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat_fast;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Issue one request (caller sits just after a rising edge), then count
  // edges until each instance strobes done. Edges stall_from..stall_from+len-1
  // are stalled; at edge bogus_at a foreign request is presented.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int stall_from, input int stall_len, input int bogus_at,
                       output logic [31:0] rd_s, output int lat_s,
                       output logic [31:0] rd_f, output int lat_f);
    logic [31:0] rd_hold;
    bit got_s, got_f;
    got_s = 0; got_f = 0;
    lat_s = -1; lat_f = -1; rd_s = '0; rd_f = '0;
    valid = 1'b1; fun = f; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    valid = 1'b0; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678; fun = F_DIV;
    for (int n = 1; n <= 80; n++) begin
      stall = (n >= stall_from) && (n < stall_from + stall_len);
      if (n == bogus_at) begin
        valid = 1'b1; fun = F_DIVU; rs1 = 32'd9; rs2 = 32'd3;
      end
      rd_hold = bus_s.x_rd_o;
      @(posedge clk); #1;
      valid = 1'b0;
      if (stall) begin
        check("rd_frozen_in_stall", bus_s.x_rd_o, rd_hold);
        check("busy_held_in_stall", {31'd0, bus_s.x_busy_o}, 32'd1);
      end
      if (!got_s && bus_s.x_done_o) begin got_s = 1; lat_s = n; rd_s = bus_s.x_rd_o; end
      if (!got_f && bus_f.x_done_o) begin got_f = 1; lat_f = n; rd_f = bus_f.x_rd_o; end
      if (got_s && got_f) break;
    end
    stall = 1'b0;
  endtask

  vec_t vecs[$];
  logic [31:0] rs, rf;
  int ls, lf;

  initial begin
    vecs.push_back('{F_DIVU, 32'd100,        32'd7,          32'd14,         33});
    vecs.push_back('{F_REMU, 32'd100,        32'd7,          32'd2,          33});
    vecs.push_back('{F_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
    vecs.push_back('{F_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
    vecs.push_back('{F_DIV,  32'd7,          32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{F_REM,  32'd7,          32'd0,          32'd7,          1});
    vecs.push_back('{F_REMU, 32'h8000_0000,  32'd0,          32'h8000_0000,  1});
    vecs.push_back('{F_DIVU, 32'd7,          32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33});
    vecs.push_back('{F_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  33});
    vecs.push_back('{F_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33});
    vecs.push_back('{F_DIV,  32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA,  33});
    vecs.push_back('{F_REM,  32'd20,         32'hFFFF_FFFD,  32'd2,          33});
    vecs.push_back('{F_DIVU, 32'hFFFF_FFFF,  32'd10,         32'h1999_9999,  33});
    vecs.push_back('{F_REMU, 32'hFFFF_FFFF,  32'd10,         32'd5,          33});

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_busy", {31'd0, bus_s.x_busy_o}, 32'd0);
    check("reset_done", {31'd0, bus_s.x_done_o}, 32'd0);
    check("reset_rd",   bus_s.x_rd_o, 32'd0);

    // Non-divide funct3 is ignored
    valid = 1'b1; fun = 3'b001; rs1 = 32'd5; rs2 = 32'd1;
    @(posedge clk); #1;
    valid = 1'b0;
    check("ignore_0xx_busy", {31'd0, bus_s.x_busy_o}, 32'd0);

    // Directed vector table
    foreach (vecs[i]) begin
      do_op(vecs[i].fun, vecs[i].a, vecs[i].b, 0, 0, 0, rs, ls, rf, lf);
      check($sformatf("vec%0d_rd_slow", i), rs, vecs[i].exp);
      check_int($sformatf("vec%0d_lat_slow", i), ls, 33);
      check($sformatf("vec%0d_rd_fast", i), rf, vecs[i].exp);
      check_int($sformatf("vec%0d_lat_fast", i), lf, vecs[i].lat_fast);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_one_cycle", i), {31'd0, bus_s.x_done_o}, 32'd0);
      check($sformatf("vec%0d_rd_holds", i), bus_s.x_rd_o, vecs[i].exp);
    end

    // Stall for 5 cycles in CALC plus an ignored request while busy
    do_op(F_DIVU, 32'd1000, 32'd10, 10, 5, 20, rs, ls, rf, lf);
    check("stall_rd", rs, 32'd100);
    check_int("stall_lat", ls, 38);
    @(posedge clk); #1;

    // Reset mid-operation at E10
    valid = 1'b1; fun = F_DIV; rs1 = 32'd12345; rs2 = 32'd7;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", {31'd0, bus_s.x_busy_o}, 32'd0);
    check("midrst_rd",   bus_s.x_rd_o, 32'd0);
    begin
      int seen = 0;
      for (int n = 0; n < 40; n++) begin
        @(posedge clk); #1;
        if (bus_s.x_done_o) seen++;
      end
      check_int("midrst_no_done", seen, 0);
    end

    // Fresh op after reset, then DONE held by a stall
    do_op(F_DIVU, 32'd9, 32'd3, 0, 0, 0, rs, ls, rf, lf);
    check("post_rst_rd", rs, 32'd3);
    check_int("post_rst_lat", ls, 33);
    stall = 1'b1;
    @(posedge clk); #1;
    check("done_persists_stall", {31'd0, bus_s.x_done_o}, 32'd1);
    stall = 1'b0;

    // Back-to-back: next request presented during the DONE cycle
    do_op(F_DIV, 32'hFFFF_FF9C, 32'd7, 0, 0, 0, rs, ls, rf, lf);
    check("b2b_first_rd", rs, 32'hFFFF_FFF2);
    do_op(F_REMU, 32'd1000, 32'd33, 0, 0, 0, rs, ls, rf, lf);
    check("b2b_second_rd", rs, 32'd10);
    check_int("b2b_second_lat", ls, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
